regfile_mp_sb: RTL and testbench

//  Parametrised multi-port integer register file with a built-in scoreboard of busy bits, for the pipelined core.
//  - Writes land on the rising edge of the clock.
//  - Same-cycle write-to-read bypass replaces the negedge-write writeback scheme.
//  - Decode reads operands and per-operand busy flags; issue reserves destinations; writeback clears them.

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 75 +++++++
 rtl/regfile_mp_sb.sv | 109 ++++++++++
 tb/tb_regfile_mp_sb.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file with scoreboard.
package rf_pkg;

    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned AW_DEFAULT    = $clog2(NREGS_DEFAULT);
    localparam int unsigned ZERO_ADDR     = 0;

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xlen_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: reserve sets, writeback clears, flush clears all.
// busy_count tracks the popcount of the busy vector incrementally.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS    = NREGS_DEFAULT,
    parameter int unsigned AW       = $clog2(NREGS),
    parameter int unsigned NWR      = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR-1:0][AW-1:0] wr_addr,
    input  logic                   rsv_en,
    input  logic [AW-1:0]          rsv_addr,
    input  logic                   flush,
    output logic [NREGS-1:0]       busy,
    output logic [AW:0]            busy_count
);

    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] newly_set;
    logic [NREGS-1:0] newly_clr;
    logic [NREGS-1:0] busy_next;
    logic [AW:0]      n_set;
    logic [AW:0]      n_clr;
    logic [AW:0]      count_next;

    // Next-state busy vector and count delta; set beats clear, flush beats both
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (rsv_en) begin
            set_mask[rsv_addr] = 1'b1;
        end
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en[j]) begin
                clr_mask[wr_addr[j]] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            set_mask[ZERO_ADDR] = 1'b0;
            clr_mask[ZERO_ADDR] = 1'b0;
        end
        newly_set = set_mask & ~busy;
        // Duplicate write addresses collapse in the mask, so a bit is counted once
        newly_clr = clr_mask & ~set_mask & busy;
        n_set     = (AW+1)'(|newly_set);
        n_clr     = '0;
        for (int unsigned k = 0; k < NREGS; k++) begin
            n_clr = n_clr + (AW+1)'(newly_clr[k]);
        end
        if (flush) begin
            busy_next  = '0;
            count_next = '0;
        end else begin
            busy_next  = (busy & ~clr_mask) | set_mask;
            count_next = busy_count + n_set - n_clr;
        end
    end

    // Busy bits and their registered population count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with same-cycle write bypass and a
// busy-bit scoreboard for destination tracking in the pipelined core.
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEFAULT,
    parameter int unsigned NREGS    = NREGS_DEFAULT,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned AW       = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    input  logic                     flush,
    output logic [AW:0]              busy_count
);

    if (NREGS < 2 || NREGS != (1 << AW)) begin : g_bad_nregs
        $error("regfile_mp_sb: NREGS must be a power of 2 >= 2 matching AW");
    end
    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("regfile_mp_sb: NRD must be 1..4");
    end
    if (NWR < 1 || NWR > 2) begin : g_bad_nwr
        $error("regfile_mp_sb: NWR must be 1..2");
    end
    if (ZERO_REG > 1 || BYPASS > 1) begin : g_bad_flags
        $error("regfile_mp_sb: ZERO_REG and BYPASS must be 0 or 1");
    end

    logic [XLEN-1:0] mem [NREGS];
    logic [NWR-1:0]  wr_keep;
    logic [NREGS-1:0] busy;

    // Enabled writes that actually land (writes to x0 dropped when hardwired)
    always_comb begin
        wr_keep = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            wr_keep[j] = wr_en[j] &&
                         !((ZERO_REG != 0) && (wr_addr[j] == AW'(ZERO_ADDR)));
        end
    end

    // Storage; ascending port loop lets the highest-numbered port win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NREGS; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (wr_keep[j]) begin
                    mem[wr_addr[j]] <= wr_data[j];
                end
            end
        end
    end

    // Read ports: stored value, optionally overridden by this cycle's write
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_data[i] = mem[rd_addr[i]];
            rd_busy[i] = busy[rd_addr[i]];
            if (BYPASS != 0) begin
                for (int unsigned j = 0; j < NWR; j++) begin
                    if (wr_keep[j] && (wr_addr[j] == rd_addr[i])) begin
                        rd_data[i] = wr_data[j];
                        rd_busy[i] = 1'b0;
                    end
                end
            end
            // Reset gating keeps the bypass path from leaking write data during reset
            if (((ZERO_REG != 0) && (rd_addr[i] == AW'(ZERO_ADDR))) || !rst_n) begin
                rd_data[i] = '0;
                rd_busy[i] = 1'b0;
            end
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_keep),
        .wr_addr    (wr_addr),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .flush      (flush),
        .busy       (busy),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard-style bench for regfile_mp_sb: a bypassing instance (a) and a
// non-bypassing instance (b) share all inputs; directed vectors push expected
// values, a monitor process pops and compares.
`timescale 1ns/1ps
module tb_regfile_mp_sb;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data_a, rd_data_b;
    logic [1:0]       rd_busy_a, rd_busy_b;
    logic [1:0]       wr_en;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic             rsv_en;
    logic [4:0]       rsv_addr;
    logic             flush;
    logic [5:0]       cnt_a, cnt_b;

    always #5 clk = ~clk;

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .flush(flush), .busy_count(cnt_a)
    );

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .flush(flush), .busy_count(cnt_b)
    );

    // kind: 0 a.rd_data, 1 a.rd_busy, 2 a.busy_count, 3 b.rd_data, 4 b.rd_busy, 5 b.busy_count
    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    event mon_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic exp_push(input string nm, input int kind, input int idx, input logic [31:0] v);
        exp_t e;
        e.name = nm; e.kind = kind; e.idx = idx; e.exp = v;
        q.push_back(e);
    endtask

    // Monitor: each strobe means DUT outputs are presented; drain the queue
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(mon_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.kind)
                    0: act = rd_data_a[e.idx];
                    1: act = {31'd0, rd_busy_a[e.idx]};
                    2: act = {26'd0, cnt_a};
                    3: act = rd_data_b[e.idx];
                    4: act = {31'd0, rd_busy_b[e.idx]};
                    default: act = {26'd0, cnt_b};
                endcase
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic check();
        ->mon_ev;
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL monitor_drain: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        rd_addr = '0;
        #2;
        exp_push("reset_data", 0, 0, 32'h0);
        exp_push("reset_count", 2, 0, 32'd0);
        check();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: write x5 and reserve x6, then asynchronous reset clears everything
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
        rsv_en = 1'b1; rsv_addr = 5'd6;
        rd_addr[0] = 5'd5; rd_addr[1] = 5'd6;
        #1;
        exp_push("t1_bypass_a", 0, 0, 32'hDEADBEEF);
        exp_push("t1_nobypass_b", 3, 0, 32'h0);
        exp_push("t1_busy_pre", 1, 1, 32'd0);
        exp_push("t1_count_pre", 2, 0, 32'd0);
        check();
        cyc();
        #1;
        exp_push("t1_stored_a", 0, 0, 32'hDEADBEEF);
        exp_push("t1_stored_b", 3, 0, 32'hDEADBEEF);
        exp_push("t1_busy_x6", 1, 1, 32'd1);
        exp_push("t1_count_1", 2, 0, 32'd1);
        check();
        rst_n = 1'b0;
        #1;
        exp_push("t1_rst_data_a", 0, 0, 32'h0);
        exp_push("t1_rst_data_b", 3, 0, 32'h0);
        exp_push("t1_rst_busy", 1, 1, 32'd0);
        exp_push("t1_rst_count", 2, 0, 32'd0);
        check();
        @(negedge clk);
        rst_n = 1'b1;

        // 2: same-cycle bypass vs. next-cycle visibility
        wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'h12345678;
        rd_addr[0] = 5'd7;
        #1;
        exp_push("t2_bypass_a", 0, 0, 32'h12345678);
        exp_push("t2_old_b", 3, 0, 32'h0);
        check();
        cyc();
        #1;
        exp_push("t2_next_b", 3, 0, 32'h12345678);
        exp_push("t2_next_a", 0, 0, 32'h12345678);
        check();

        // 3: zero register ignores writes and reservations
        cyc();
        wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFFFFFF;
        rd_addr[0] = 5'd0;
        #1;
        exp_push("t3_x0_bypass", 0, 0, 32'h0);
        exp_push("t3_x0_busy", 1, 0, 32'd0);
        check();
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd0;
        cyc();
        #1;
        exp_push("t3_x0_data_a", 0, 0, 32'h0);
        exp_push("t3_x0_data_b", 3, 0, 32'h0);
        exp_push("t3_x0_busy_after", 1, 0, 32'd0);
        exp_push("t3_count", 2, 0, 32'd0);
        check();

        // 4: two write ports to one address, port 1 wins
        cyc();
        wr_en = 2'b11; wr_addr[0] = 5'd3; wr_addr[1] = 5'd3;
        wr_data[0] = 32'h1; wr_data[1] = 32'h2;
        rd_addr[0] = 5'd3;
        #1;
        exp_push("t4_bypass_hi", 0, 0, 32'h2);
        check();
        cyc();
        #1;
        exp_push("t4_stored_a", 0, 0, 32'h2);
        exp_push("t4_stored_b", 3, 0, 32'h2);
        check();

        // 5: reserve, writeback clear, reserve+write collision
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd4;
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        #1;
        exp_push("t5_count_1", 2, 0, 32'd1);
        check();
        cyc();
        rd_addr[0] = 5'd4; rd_addr[1] = 5'd9;
        #1;
        exp_push("t5_count_2", 2, 0, 32'd2);
        exp_push("t5_busy_x4", 1, 0, 32'd1);
        exp_push("t5_busy_x9", 1, 1, 32'd1);
        check();
        cyc();
        wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 32'hAA;
        #1;
        exp_push("t5_wb_busy_a", 1, 0, 32'd0);
        exp_push("t5_wb_busy_b", 4, 0, 32'd1);
        exp_push("t5_wb_count", 2, 0, 32'd2);
        check();
        cyc();
        #1;
        exp_push("t5_after_wb_count", 2, 0, 32'd1);
        exp_push("t5_after_wb_busy", 4, 0, 32'd0);
        check();
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h55;
        #1;
        exp_push("t5_rsvwr_busy_a", 1, 1, 32'd0);
        exp_push("t5_rsvwr_busy_b", 4, 1, 32'd1);
        check();
        cyc();
        #1;
        exp_push("t5_x9_still_busy", 1, 1, 32'd1);
        exp_push("t5_x9_count", 2, 0, 32'd1);
        exp_push("t5_x9_data", 0, 1, 32'h55);
        check();

        // dual-port clear of one busy register decrements once
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd11;
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd12;
        cyc();
        wr_en = 2'b11; wr_addr[0] = 5'd11; wr_addr[1] = 5'd11;
        wr_data[0] = 32'h11; wr_data[1] = 32'h22;
        rd_addr[0] = 5'd11; rd_addr[1] = 5'd12;
        #1;
        exp_push("dual_pre_count", 2, 0, 32'd3);
        exp_push("dual_pre_busy_b", 4, 0, 32'd1);
        check();
        cyc();
        #1;
        exp_push("dual_count", 2, 0, 32'd2);
        exp_push("dual_busy_x11", 4, 0, 32'd0);
        exp_push("dual_busy_x12", 4, 1, 32'd1);
        exp_push("dual_count_b", 5, 0, 32'd2);
        check();

        // 6: fill the scoreboard, then flush overriding a reservation
        for (int k = 1; k < 32; k++) begin
            cyc();
            rsv_en = 1'b1; rsv_addr = 5'(k);
        end
        cyc();
        rd_addr[0] = 5'd31; rd_addr[1] = 5'd0;
        #1;
        exp_push("t6_full_count", 2, 0, 32'd31);
        exp_push("t6_busy_x31", 1, 0, 32'd1);
        exp_push("t6_x0_not_busy", 1, 1, 32'd0);
        check();
        cyc();
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd2;
        wr_en = 2'b01; wr_addr[0] = 5'd10; wr_data[0] = 32'h77;
        rd_addr[0] = 5'd2; rd_addr[1] = 5'd10;
        #1;
        exp_push("t6_pre_busy_x2", 1, 0, 32'd1);
        exp_push("t6_pre_busy_x10", 1, 1, 32'd0);
        exp_push("t6_pre_count", 2, 0, 32'd31);
        check();
        cyc();
        #1;
        exp_push("t6_flush_count", 2, 0, 32'd0);
        exp_push("t6_flush_busy_x2", 4, 0, 32'd0);
        exp_push("t6_flush_busy_x10", 4, 1, 32'd0);
        exp_push("t6_flush_data_a", 0, 1, 32'h77);
        exp_push("t6_flush_data_b", 3, 1, 32'h77);
        check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
